// File: rtl/rx_spart.sv
// SPART receiver: 8N1 deframer driven by a 16x (OVERSAMPLE) baud tick.
// Presents each byte with rda/framing_err/overrun, cleared by a read of ioaddr 2'b00.
module rx_spart #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       brg_tick,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err,
    output logic       overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          rxd_meta;
    logic          rxd_s;
    logic          rd;
    logic          load;

    assign rd   = (ioaddr == 2'b00) && iorw;
    assign load = (state == STOP) && brg_tick && (tick_cnt == TICK_LAST);

    // Flops reset to 1 so an idle line is not mistaken for a start bit after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values,
            // giving a true two-stage chain instead of a single flop.
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= 8'h00;
        end else if (brg_tick) begin
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (!rxd_s)
                        state <= START;
                end
                START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        // A start bit that has gone high by mid-bit is a glitch.
                        state    <= rxd_s ? IDLE : DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tick_cnt <= tick_cnt + 1'b1;
                    if (tick_cnt == TICK_LAST) begin
                        shift_reg <= {rxd_s, shift_reg[7:1]};
                        if (bit_cnt == 3'd7)
                            state <= STOP;
                        else
                            bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A load in the same cycle as a read wins: the new byte stays available.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data     <= 8'h00;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else if (load) begin
            rx_data     <= shift_reg;
            rda         <= 1'b1;
            framing_err <= ~rxd_s;
            overrun     <= rda & ~rd;
        end else if (rd) begin
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end
    end

endmodule

// File: doc/rx_spart.md
Name: rx_spart

Overview:
Serial receive half of the SPART. It samples the asynchronous rxd line using a 16x-oversampling enable from the baud-rate generator and deframes 8N1 characters: one start bit (0), 8 data bits LSB first, one stop bit (1). Each received byte is presented on rx_data with a receive-data-available flag, which is cleared by a processor read at ioaddr 2'b00. It pairs with the SPART transmitter and uses the same ioaddr/iorw bus decode.

Parameters:
OVERSAMPLE, 16, brg_tick pulses per bit time; must be a power of two, minimum 8.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
rxd  input  1  serial receive line, asynchronous to clk, idles high
brg_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
iorw  input  1  1 = read, 0 = write
ioaddr  input  2  register select; 2'b00 = data register
rx_data  output  8  last received byte
rda  output  1  receive data available
framing_err  output  1  stop bit of the last frame sampled as 0
overrun  output  1  a new byte overwrote an unread byte

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, counters=0, shift register=8'h00, rx_data=8'h00, rda=0, framing_err=0, overrun=0, both synchronizer flops=1.
- rxd passes through a 2-flop synchronizer to give rxd_s. All decisions use rxd_s only.
- tick_cnt is log2(OVERSAMPLE) bits wide and bit_cnt is 3 bits wide. Both advance only on brg_tick.
- IDLE:
  - tick_cnt=0.
  - On brg_tick with rxd_s==0, go to START.
- START:
  - On brg_tick, tick_cnt++.
  - At the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rxd_s==0: go to DATA with tick_cnt=0 and bit_cnt=0.
    - rxd_s==1: treat as a glitch and return to IDLE. No flags change.
- DATA:
  - On brg_tick, tick_cnt++ (wraps).
  - At tick_cnt==OVERSAMPLE-1: shift right with rxd_s entering bit 7, so the first bit received ends in bit 0.
  - If bit_cnt==7, go to STOP. Otherwise bit_cnt++.
- STOP:
  - At the tick where tick_cnt==OVERSAMPLE-1 (mid stop bit), on the next clk edge:
    - rx_data <= shift register
    - rda <= 1
    - framing_err <= ~rxd_s
    - overrun <= rda & ~rd
  - Then return to IDLE. The byte is delivered even when a framing error occurs.
- Read strobe: rd = (ioaddr==2'b00 && iorw==1).
  - rd with no load in the same cycle: clears rda, framing_err and overrun on the next edge. rx_data holds its value.
  - rd and load in the same cycle: the load wins. rda=1, overrun=0, and framing_err reflects the new frame.
- Writes (iorw==0) and other ioaddr values have no effect.
- Latency:
  - A start edge is detected 2-3 clk after rxd falls, then up to one tick of alignment.
  - rda rises 1 clk after the mid-stop brg_tick, which is about 9.5 bit times after the start edge.
- No receive gating during a frame. rxd activity mid-frame is simply sampled.
- After STOP, IDLE re-arms immediately, so back-to-back frames with a single stop bit are received.
- brg_tick held low freezes the FSM. rd still works.
- Reset mid-frame aborts the frame immediately. The partial byte is discarded and no rda is raised.

Test Plan:
- Send 0xA5 as 8N1 at OVERSAMPLE=16 (brg_tick every 4 clk) -> rx_data=8'hA5, rda=1, framing_err=0, overrun=0; rda rises within 1 clk of the mid-stop tick; a read with ioaddr=00, iorw=1 -> rda=0 next clk, rx_data still 8'hA5.
- rxd low for 4 ticks then high (start glitch) -> FSM returns to IDLE at the 8th tick; rda stays 0 and rx_data is unchanged.
- Send 0x3C with stop bit = 0 -> rx_data=8'h3C, rda=1, framing_err=1; a following valid frame 0x01 after a read -> framing_err=0.
- Send 0x11 then 0x22 with no read in between -> rx_data=8'h22, rda=1, overrun=1; a read clears rda and overrun.
- Assert rd in exactly the clk where 0x55 loads, with rda already 1 -> rda=1, overrun=0, rx_data=8'h55.
- Pull rst low during data bit 4 of 0xF0, release, then send 0x0F -> no output during the first frame; rx_data=8'h0F, rda=1, no flags set.
